// File: rtl/player_control_if.sv
// Button, frame-window and ship/fire signals exchanged between the board/test side
// and the player input stage.
interface player_control_if;
    logic        btn_left;
    logic        btn_right;
    logic        btn_up;
    logic        btn_down;
    logic        btn_fire;
    logic        calc;
    logic [11:0] x_axis;
    logic [10:0] y_axis;
    logic        fire;
    logic        cooldown;

    modport master (
        output btn_left, btn_right, btn_up, btn_down, btn_fire, calc,
        input  x_axis, y_axis, fire, cooldown
    );

    modport slave (
        input  btn_left, btn_right, btn_up, btn_down, btn_fire, calc,
        output x_axis, y_axis, fire, cooldown
    );
endinterface

// File: rtl/player_control.sv
// Player input stage: button sync/debounce, per-frame clamped ship movement and
// the active-low fire strobe with hold time and frame-counted cooldown.
module player_control #(
    parameter int H_ACTIVE        = 1920,
    parameter int V_ACTIVE        = 1080,
    parameter int SIZE            = 32,
    parameter int SPEED           = 4,
    parameter int BOTTOM_MARGIN   = 16,
    parameter int DEBOUNCE        = 50000,
    parameter int FIRE_HOLD       = 32,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic             clock,
    input  logic             reset,
    player_control_if.slave  bus
);
    localparam int          NBTN      = 5;
    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE - 1);
    localparam logic [15:0] HOLD_LAST = 16'(FIRE_HOLD - 1);
    localparam logic [4:0]  COOL_N    = 5'(COOLDOWN_FRAMES);
    localparam logic [11:0] X_MAX     = 12'(H_ACTIVE - SIZE);
    localparam logic [10:0] Y_MAX     = 11'(V_ACTIVE - SIZE);
    localparam logic [11:0] X_RST     = 12'((H_ACTIVE - SIZE) / 2);
    localparam logic [10:0] Y_RST     = 11'(V_ACTIVE - SIZE - BOTTOM_MARGIN);
    localparam logic [12:0] X_SPEED   = 13'(SPEED);
    localparam logic [11:0] Y_SPEED   = 12'(SPEED);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOOT = 2'd1,
        ST_COOL  = 2'd2
    } fire_state_e;

    // Index order: 0 left, 1 right, 2 up, 3 down, 4 fire (all active-low).
    logic [NBTN-1:0]       raw_s;
    logic [NBTN-1:0]       sync1_q, sync2_q, deb_q, deb_d;
    logic [NBTN-1:0][15:0] cnt_q, cnt_d;
    logic                  calc_q, tick_s;
    logic [11:0]           x_q, x_d;
    logic [10:0]           y_q, y_d;
    logic [12:0]           x_ext_s, x_inc_s, x_dec_s;
    logic [11:0]           y_ext_s, y_inc_s, y_dec_s;
    logic                  left_s, right_s, up_s, down_s;
    fire_state_e           state_q, state_d;
    logic [15:0]           hold_q, hold_d;
    logic [3:0]            frame_q, frame_d;
    logic                  fire_q, fire_d, cool_q, cool_d;

    assign raw_s  = {bus.btn_fire, bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left};
    assign tick_s = bus.calc & ~calc_q;

    // Debounce: a level is accepted only after DEBOUNCE consecutive mismatching cycles.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < NBTN; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = 16'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end else begin
                cnt_d[i] = 16'd0;
            end
        end
    end

    assign left_s  = ~deb_q[0];
    assign right_s = ~deb_q[1];
    assign up_s    = ~deb_q[2];
    assign down_s  = ~deb_q[3];
    assign x_ext_s = {1'b0, x_q};
    assign x_inc_s = x_ext_s + X_SPEED;
    assign x_dec_s = x_ext_s - X_SPEED;
    assign y_ext_s = {1'b0, y_q};
    assign y_inc_s = y_ext_s + Y_SPEED;
    assign y_dec_s = y_ext_s - Y_SPEED;

    // Ship movement on frame tick, clamped in widened arithmetic so nothing wraps.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick_s) begin
            if (left_s && !right_s) begin
                x_d = (x_ext_s < X_SPEED) ? 12'd0 : x_dec_s[11:0];
            end else if (right_s && !left_s) begin
                x_d = (x_inc_s > {1'b0, X_MAX}) ? X_MAX : x_inc_s[11:0];
            end else begin
                x_d = x_q;
            end
            if (up_s && !down_s) begin
                y_d = (y_ext_s < Y_SPEED) ? 11'd0 : y_dec_s[10:0];
            end else if (down_s && !up_s) begin
                y_d = (y_inc_s > {1'b0, Y_MAX}) ? Y_MAX : y_inc_s[10:0];
            end else begin
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Fire FSM next state; outputs are registered from the next state.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        frame_d = frame_q;
        case (state_q)
            ST_IDLE: begin
                if (!deb_q[4]) begin
                    state_d = ST_SHOOT;
                    hold_d  = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHOOT: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_COOL;
                    hold_d  = 16'd0;
                    frame_d = 4'd0;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            ST_COOL: begin
                if (COOL_N == 5'd0) begin
                    state_d = ST_IDLE;
                end else if (tick_s) begin
                    if (({1'b0, frame_q} + 5'd1) == COOL_N) begin
                        state_d = ST_IDLE;
                        frame_d = 4'd0;
                    end else begin
                        frame_d = frame_q + 4'd1;
                    end
                end else begin
                    state_d = ST_COOL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = 16'd0;
                frame_d = 4'd0;
            end
        endcase
        fire_d = (state_d != ST_SHOOT);
        cool_d = (state_d != ST_IDLE);
    end

    // All state registers; reset abandons any shot and recentres the ship immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= {NBTN{1'b1}};
            sync2_q <= {NBTN{1'b1}};
            deb_q   <= {NBTN{1'b1}};
            cnt_q   <= '0;
            calc_q  <= 1'b1;
            x_q     <= X_RST;
            y_q     <= Y_RST;
            state_q <= ST_IDLE;
            hold_q  <= 16'd0;
            frame_q <= 4'd0;
            fire_q  <= 1'b1;
            cool_q  <= 1'b0;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            calc_q  <= bus.calc;
            x_q     <= x_d;
            y_q     <= y_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            frame_q <= frame_d;
            fire_q  <= fire_d;
            cool_q  <= cool_d;
        end
    end

    assign bus.x_axis   = x_q;
    assign bus.y_axis   = y_q;
    assign bus.fire     = fire_q;
    assign bus.cooldown = cool_q;
endmodule
